// File: rtl/shift_unit_pipelined.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) behind a valid/ready stream.
// Stage k shifts by 2^k, and an output register follows the last stage.
module shift_unit_pipelined #(
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // Handshake: a beat moves on an edge where valid and ready are both high.
  // The whole pipe advances as one unit, so ready depends only on the output slot.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  function automatic logic [N-1:0] shift_step(input logic [N-1:0] d,
                                              input logic [1:0]   mode,
                                              input int           s);
    logic [N-1:0] r;
    case (mode)
      MODE_SLL: r = d << s;
      MODE_SRL: r = d >> s;
      MODE_SRA: r = $unsigned($signed(d) >>> s);
      default:  r = (d >> s) | (d << (N - s));
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < AW; k++) begin : g_stage
    localparam int RW = AW - k;  // amount bits still pending on entry to this stage

    logic          src_valid;
    logic [N-1:0]  src_data;
    logic [RW-1:0] src_rem;
    logic [1:0]    src_mode;
    logic [N-1:0]  step;
    logic          valid_q;
    logic [N-1:0]  data_q;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_rem   = in_amt;
      assign src_mode  = in_mode;
    end else begin : g_body
      assign src_valid = g_stage[k-1].valid_q;
      assign src_data  = g_stage[k-1].data_q;
      assign src_rem   = g_stage[k-1].g_fwd.rem_q;
      assign src_mode  = g_stage[k-1].g_fwd.mode_q;
    end

    assign step = src_rem[0] ? shift_step(src_data, src_mode, 1 << k) : src_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (adv) begin
        valid_q <= src_valid;
        data_q  <= step;
      end
    end

    // The final stage has no successor, so it drops the amount and mode fields.
    if (k < AW - 1) begin : g_fwd
      logic [RW-2:0] rem_q;
      logic [1:0]    mode_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_q  <= '0;
          mode_q <= '0;
        end else if (adv) begin
          rem_q  <= src_rem[RW-1:1];
          mode_q <= src_mode;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= g_stage[AW-1].valid_q;
      out_data  <= g_stage[AW-1].data_q;
    end
  end

endmodule

// File: tb/tb_shift_unit_pipelined.sv
// Scoreboard bench for shift_unit_pipelined: directed N=8 vectors plus
// random runs at N=8/16/32 on separate instances.
module tb_shift_unit_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a,
                                            input logic [1:0] m, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'd0:    r[i] = (i >= a) ? d[i-a] : 1'b0;
        2'd1:    r[i] = (i + a < n) ? d[i+a] : 1'b0;
        2'd2:    r[i] = (i + a < n) ? d[i+a] : d[n-1];
        default: r[i] = d[(i+a)%n];
      endcase
    end
    return r;
  endfunction

  // ---------------- directed N=8 instance ----------------
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;

  shift_unit_pipelined #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  logic [7:0] exp_q[$];
  int         lat_q[$];
  int         out_cnt = 0;
  bit         lat_en = 1'b1;

  // Monitor: an output transfer is visible at the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) chk("spurious_out", 32'(out_data), 32'hdead);
      else begin
        logic [7:0] e;
        int         l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("data8", 32'(out_data), 32'(e));
        if (l >= 0) chk("latency8", cyc - l, 3);
      end
    end
  end

  // Called at posedge+1; holds the beat until it is accepted.
  task automatic send(input logic v, input logic [7:0] d, input logic [2:0] a,
                      input logic [1:0] m, input logic [7:0] e);
    in_valid = v;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (v) begin
          exp_q.push_back(e);
          lat_q.push_back(lat_en ? cyc + 1 : -1);
        end
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- random runs at three widths ----------------
  for (genvar g = 0; g < 3; g++) begin : g_run
    localparam int W = 8 << g;
    localparam int A = $clog2(W);

    logic         v, rdy, ov, ordy, rn;
    logic [W-1:0] d, od;
    logic [A-1:0] a;
    logic [1:0]   m;
    logic [W-1:0] q[$];
    int           lq[$];
    bit           done = 1'b0;

    shift_unit_pipelined #(.N(W)) dut_r (
      .clk(clk), .rst_n(rn),
      .in_valid(v), .in_ready(rdy), .in_data(d), .in_amt(a), .in_mode(m),
      .out_valid(ov), .out_ready(ordy), .out_data(od)
    );

    always @(negedge clk) begin
      if (rn && ov && ordy) begin
        if (q.size() == 0) chk($sformatf("w%0d_spurious", W), 0, 1);
        else begin
          logic [W-1:0] e;
          int           l;
          e = q.pop_front();
          l = lq.pop_front();
          chk($sformatf("w%0d_data", W), 32'(od), 32'(e));
          if (l >= 0) chk($sformatf("w%0d_latency", W), cyc - l, A);
        end
      end
    end

    initial begin
      int           sent;
      bit           pend;
      logic [W-1:0] nd;
      int           na;
      logic [1:0]   nm;
      sent = 0; pend = 1'b0; nd = '0; na = 0; nm = '0;
      v = 1'b0; d = '0; a = '0; m = '0; ordy = 1'b1; rn = 1'b0;
      repeat (2) @(posedge clk);
      #2 rn = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
        if (!pend) begin
          pend = (c == 0) || ($urandom_range(0, 3) != 0);
          nd   = W'({$urandom(), $urandom()});
          na   = $urandom_range(0, W - 1);
          nm   = 2'($urandom_range(0, 3));
        end
        v    = pend;
        d    = nd;
        a    = A'(na);
        m    = nm;
        ordy = (c < 8) || ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (v && rdy) begin
          q.push_back(W'(ref_shift(32'(nd), na, nm, W)));
          lq.push_back(sent == 0 ? cyc + 1 : -1);
          sent++;
          pend = 1'b0;
        end
        @(posedge clk); #1;
      end
      v = 1'b0;
      ordy = 1'b1;
      for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
      #1;
      chk($sformatf("w%0d_sent", W), sent, 1000);
      chk($sformatf("w%0d_drained", W), q.size(), 0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    #2 rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // same operand, four modes back to back
    send(1'b1, 8'b1011_0101, 3'd3, 2'd0, 8'b1010_1000);
    send(1'b1, 8'b1011_0101, 3'd3, 2'd1, 8'b0001_0110);
    send(1'b1, 8'b1011_0101, 3'd3, 2'd2, 8'b1111_0110);
    send(1'b1, 8'b1011_0101, 3'd3, 2'd3, 8'b1011_0110);
    drain();

    // extremes and zero shift
    send(1'b1, 8'h75, 3'd7, 2'd2, 8'h00);
    send(1'b1, 8'h80, 3'd7, 2'd2, 8'hFF);
    send(1'b1, 8'h80, 3'd7, 2'd3, 8'h01);
    send(1'b1, 8'hB5, 3'd7, 2'd0, 8'h80);
    send(1'b1, 8'hB5, 3'd7, 2'd1, 8'h01);
    for (int md = 0; md < 4; md++) send(1'b1, 8'hC3, 3'd0, 2'(md), 8'hC3);
    drain();

    // backpressure: six back-to-back beats, four-cycle output stall
    lat_en = 1'b0;
    c0 = out_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] rd;
          logic [2:0] ra;
          logic [1:0] rm;
          rd = 8'($urandom_range(0, 255));
          ra = 3'($urandom_range(0, 7));
          rm = 2'($urandom_range(0, 3));
          send(1'b1, rd, ra, rm, 8'(ref_shift(32'(rd), int'(ra), rm, 8)));
        end
        in_valid = 1'b0;
      end
      begin
        logic [7:0] held;
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_data", 32'(out_data), 32'(held));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", out_cnt - c0, 6);

    // bubbles: valid pattern 1,0,1,1,0,1
    lat_en = 1'b1;
    c0 = out_cnt;
    send(1'b1, 8'h0F, 3'd4, 2'd0, 8'hF0);
    send(1'b0, 8'hAA, 3'd1, 2'd0, 8'h00);
    send(1'b1, 8'hF0, 3'd4, 2'd1, 8'h0F);
    send(1'b1, 8'h81, 3'd1, 2'd3, 8'hC0);
    send(1'b0, 8'h55, 3'd2, 2'd1, 8'h00);
    send(1'b1, 8'h40, 3'd2, 2'd2, 8'h10);
    drain();
    chk("bubble_count", out_cnt - c0, 4);

    // reset mid-stream with a result held at the output
    out_ready = 1'b0;
    send(1'b1, 8'h33, 3'd1, 2'd0, 8'h66);
    send(1'b1, 8'h44, 3'd2, 2'd1, 8'h11);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("pre_reset_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid_drop", 32'(out_valid), 0);
    chk("reset_data_zero", 32'(out_data), 0);
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("post_reset_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    c0 = out_cnt;
    repeat (6) @(posedge clk);
    #1 chk("no_stale_out", out_cnt - c0, 0);
    send(1'b1, 8'h01, 3'd7, 2'd0, 8'h80);
    drain();
    chk("post_reset_count", out_cnt - c0, 1);

    for (int t = 0; t < 30000 && !(g_run[0].done && g_run[1].done && g_run[2].done); t++)
      @(posedge clk);
    chk("random_runs_done", 32'(g_run[0].done && g_run[1].done && g_run[2].done), 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
